// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy engine: FSM state encoding and the
// copy-direction decision used to make overlapping copies behave like memmove.
package mem_copy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Descending copy is needed when the destination starts inside the source
    // window (measured modulo 2^k); otherwise ascending order is safe.
    function automatic logic copy_desc(input logic [31:0] src,
                                       input logic [31:0] dst,
                                       input logic [31:0] len,
                                       input int unsigned k);
        logic [31:0] mask;
        logic [31:0] d;
        mask = (k >= 32) ? '1 : ((32'd1 << k) - 32'd1);
        d    = (dst - src) & mask;
        return (d != 32'd0) && (d < len);
    endfunction

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Source/destination address stepping and remaining-word count for the copy
// engine. Direction is captured on load and holds for the whole copy.
module mem_copy_addr_gen #(
    parameter int unsigned K = 10
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         desc_i,
    input  logic [K-1:0] src_i,
    input  logic [K-1:0] dst_i,
    input  logic [K:0]   len_i,
    output logic [K-1:0] src_addr_o,
    output logic [K-1:0] dst_addr_o,
    output logic         last_o
);

    logic [K-1:0] src_q, src_d;
    logic [K-1:0] dst_q, dst_d;
    logic [K:0]   cnt_q, cnt_d;
    logic         desc_q, desc_d;

    // Next-state: load start addresses (top of window when descending), or step.
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        cnt_d  = cnt_q;
        desc_d = desc_q;
        if (load_i) begin
            desc_d = desc_i;
            cnt_d  = len_i;
            if (desc_i) begin
                // len of 2^K has low bits 0, so this still lands on src-1 mod 2^K
                src_d = src_i + len_i[K-1:0] - K'(1);
                dst_d = dst_i + len_i[K-1:0] - K'(1);
            end else begin
                src_d = src_i;
                dst_d = dst_i;
            end
        end else if (step_i) begin
            src_d = desc_q ? (src_q - K'(1)) : (src_q + K'(1));
            dst_d = desc_q ? (dst_q - K'(1)) : (dst_q + K'(1));
            cnt_d = cnt_q - (K+1)'(1);
        end
    end

    // Address/count registers, cleared by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            desc_q <= 1'b0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            cnt_q  <= cnt_d;
            desc_q <= desc_d;
        end
    end

    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
    // The word being written now is the final one.
    assign last_o     = (cnt_q == (K+1)'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// Memory-to-memory copy engine driving a single-port memory (A/WD/WE/RA).
// Each word costs a READ cycle and a WRITE cycle; overlapping copies pick
// their direction so the result matches memmove.
// Optional: define MEM_COPY_CSUM_EN to add the csum output (mod-2^M sum of
// all words written by the last copy).
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int unsigned M = 8,
    parameter int unsigned K = 10
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [K-1:0] src,
    input  logic [K-1:0] dst,
    input  logic [K:0]   len,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] mem_a,
    output logic [M-1:0] mem_wd,
    output logic         mem_we,
`ifdef MEM_COPY_CSUM_EN
    output logic [M-1:0] csum,
`endif
    input  logic [M-1:0] mem_ra
);

    localparam logic [K:0] MAX_LEN = {1'b1, {K{1'b0}}};

    state_e       state_q, state_d;
    logic [M-1:0] data_q, data_d;
    logic [K:0]   len_eff;
    logic         desc;
    logic         ag_load, ag_step, ag_last;
    logic [K-1:0] src_addr, dst_addr;

    assign len_eff = (len > MAX_LEN) ? MAX_LEN : len;
    assign desc    = copy_desc(32'(src), 32'(dst), 32'(len_eff), K);

    mem_copy_addr_gen #(.K(K)) u_addr_gen (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (ag_load),
        .step_i     (ag_step),
        .desc_i     (desc),
        .src_i      (src),
        .dst_i      (dst),
        .len_i      (len_eff),
        .src_addr_o (src_addr),
        .dst_addr_o (dst_addr),
        .last_o     (ag_last)
    );

    // FSM next-state and Moore outputs; memory port idles at zero.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        busy    = 1'b0;
        done    = 1'b0;
        mem_a   = '0;
        mem_wd  = '0;
        mem_we  = 1'b0;
        ag_load = 1'b0;
        ag_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ag_load = 1'b1;
                    state_d = (len_eff == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                busy    = 1'b1;
                mem_a   = src_addr;
                data_d  = mem_ra;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy    = 1'b1;
                mem_a   = dst_addr;
                mem_wd  = data_q;
                mem_we  = 1'b1;
                ag_step = 1'b1;
                state_d = ag_last ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and data register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

`ifdef MEM_COPY_CSUM_EN
    logic [M-1:0] csum_q, csum_d;

    // Running sum: cleared on an accepted start, accumulates each written word.
    always_comb begin
        csum_d = csum_q;
        if (state_q == ST_IDLE && start)
            csum_d = '0;
        else if (state_q == ST_WRITE)
            csum_d = csum_q + data_q;
    end

    // Checksum register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: attached single-port memory, a memmove-level
// reference that predicts every cycle's outputs, and directed copies.
module tb_mem_copy_engine;
    localparam int M = 8;
    localparam int K = 10;
    localparam int DEPTH = 1 << K;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [K-1:0] src = '0;
    logic [K-1:0] dst = '0;
    logic [K:0]   len = '0;
    logic         busy, done, mem_we;
    logic [K-1:0] mem_a;
    logic [M-1:0] mem_wd, mem_ra;
`ifdef MEM_COPY_CSUM_EN
    logic [M-1:0] csum;
`endif

    logic [M-1:0] mem [DEPTH];

    mem_copy_engine #(.M(M), .K(K)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .mem_a   (mem_a),
        .mem_wd  (mem_wd),
        .mem_we  (mem_we),
`ifdef MEM_COPY_CSUM_EN
        .csum    (csum),
`endif
        .mem_ra  (mem_ra)
    );

    assign mem_ra = mem[mem_a];
    always @(posedge clock) if (mem_we) mem[mem_a] <= mem_wd;
    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int ecyc = 0;
    int st_cyc = 0;
    bit mdl_active = 1'b0;
    int mdl_n = 0;
    int exp_ra [DEPTH];
    int exp_wa [DEPTH];
    int exp_wd [DEPTH];
    int exp_csum = 0;
    int we_cnt = 0;
    int busy_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clock) ecyc <= ecyc + 1;

    // Per-cycle compare against the memmove-level reference.
    always @(negedge clock) begin
        int c, w, ea, ewd;
        bit ebusy, edone, ewe;
        if (mem_we) we_cnt++;
        if (busy) busy_cnt++;
        ebusy = 0; edone = 0; ewe = 0; ea = 0; ewd = 0; c = 0;
        if (mdl_active) begin
            c = ecyc - st_cyc;
            if (c >= 1 && c <= 2 * mdl_n) begin
                ebusy = 1;
                w = (c - 1) / 2;
                if (c % 2 == 1) ea = exp_ra[w];
                else begin
                    ewe = 1; ea = exp_wa[w]; ewd = exp_wd[w];
                end
            end else if (c == 2 * mdl_n + 1) edone = 1;
        end
        chk("cyc_busy", int'(busy), int'(ebusy));
        chk("cyc_done", int'(done), int'(edone));
        chk("cyc_we", int'(mem_we), int'(ewe));
        chk("cyc_a", int'(mem_a), ea);
        chk("cyc_wd", int'(mem_wd), ewd);
`ifdef MEM_COPY_CSUM_EN
        if (edone) chk("cyc_csum", int'(csum), exp_csum);
`endif
        if (edone) mdl_active = 0;
    end

    // Build expected read/write sequence from memmove rules, then issue start.
    // Called #1 after a posedge; returns #1 after the start edge.
    task automatic arm(input int s, input int d, input int l);
        int n, dd, i;
        bit desc;
        n = (l > DEPTH) ? DEPTH : l;
        dd = (((d - s) % DEPTH) + DEPTH) % DEPTH;
        desc = (dd > 0) && (dd < n);
        exp_csum = 0;
        for (int w = 0; w < n; w++) begin
            i = desc ? (n - 1 - w) : w;
            exp_ra[w] = (s + i) % DEPTH;
            exp_wa[w] = (d + i) % DEPTH;
            exp_wd[w] = int'(mem[exp_ra[w]]);
            exp_csum = (exp_csum + exp_wd[w]) % (1 << M);
        end
        mdl_n = n;
        st_cyc = ecyc;
        mdl_active = 1;
        start = 1; src = K'(s); dst = K'(d); len = (K+1)'(l);
        @(posedge clock); #1;
        start = 0;
    endtask

    task automatic run(input int s, input int d, input int l, input bit poke, output int dcyc);
        arm(s, d, l);
        dcyc = -1;
        for (int k = 0; k < 2 * DEPTH + 20; k++) begin
            @(negedge clock);
            if (poke && ecyc - st_cyc == 2) begin
                start = 1; src = 7; dst = 9; len = 1;
            end
            if (poke && ecyc - st_cyc == 3) start = 0;
            if (done) begin
                dcyc = ecyc - st_cyc;
                if (poke) start = 1;
                break;
            end
        end
        if (dcyc < 0) begin
            total++; bad++;
            $display("FAIL done_timeout: got none want done");
            mdl_active = 0;
        end
        @(posedge clock); #1;
        start = 0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        int dc, we0, bz0;
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, we0, bz0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_a", int'(mem_a), 0);
        chk("rst_wd", int'(mem_wd), 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
        repeat (2) @(posedge clock);
        #1;

        // basic ascending copy, with start pulses ignored while busy and in DONE
        mem[0] = 11; mem[1] = 22; mem[2] = 33; mem[3] = 44;
        we0 = we_cnt;
        run(0, 100, 4, 1, dc);
        chk("asc_done_cyc", dc, 9);
        chk("asc_we_pulses", we_cnt - we0, 4);
        chk("asc_m100", int'(mem[100]), 11);
        chk("asc_m101", int'(mem[101]), 22);
        chk("asc_m102", int'(mem[102]), 33);
        chk("asc_m103", int'(mem[103]), 44);
`ifdef MEM_COPY_CSUM_EN
        chk("asc_csum", int'(csum), 110);
`endif

        // overlapping forward move -> descending
        for (int i = 0; i < 5; i++) mem[10 + i] = M'(i + 1);
        run(10, 12, 5, 1, dc);
        chk("ovl_done_cyc", dc, 11);
        for (int i = 0; i < 5; i++) chk("ovl_mem", int'(mem[12 + i]), i + 1);

        // source wraps past the top of memory
        mem[1022] = 7; mem[1023] = 8; mem[0] = 9;
        run(1022, 500, 3, 0, dc);
        chk("wrap_m500", int'(mem[500]), 7);
        chk("wrap_m501", int'(mem[501]), 8);
        chk("wrap_m502", int'(mem[502]), 9);

        // descending with both windows wrapping
        for (int i = 0; i < 8; i++) mem[(1020 + i) % DEPTH] = M'(100 + i);
        run(1020, 2, 8, 0, dc);
        for (int i = 0; i < 8; i++) chk("dwrap_mem", int'(mem[2 + i]), 100 + i);

        // zero length
        we0 = we_cnt; bz0 = busy_cnt;
        run(5, 6, 0, 0, dc);
        chk("zero_done_cyc", dc, 1);
        chk("zero_we", we_cnt - we0, 0);
        chk("zero_busy", busy_cnt - bz0, 0);

        // reset mid-copy after the second write
        for (int i = 0; i < 8; i++) begin
            mem[200 + i] = M'(50 + i);
            mem[600 + i] = '0;
        end
        arm(200, 600, 8);
        repeat (4) @(posedge clock);
        #1;
        mdl_active = 0;
        reset_n = 0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_we", int'(mem_we), 0);
        chk("abort_a", int'(mem_a), 0);
        chk("abort_wd", int'(mem_wd), 0);
        chk("abort_done", int'(done), 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
        repeat (2) @(posedge clock);
        #1;
        chk("abort_m600", int'(mem[600]), 50);
        chk("abort_m601", int'(mem[601]), 51);
        for (int i = 2; i < 8; i++) chk("abort_untouched", int'(mem[600 + i]), 0);
        run(200, 600, 8, 0, dc);
        chk("after_done_cyc", dc, 17);
        for (int i = 0; i < 8; i++) chk("after_mem", int'(mem[600 + i]), 50 + i);

        // oversize length saturates to full memory; src==dst leaves contents intact
        we0 = we_cnt;
        run(300, 300, DEPTH + 5, 0, dc);
        chk("sat_done_cyc", dc, 2 * DEPTH + 1);
        chk("sat_we_pulses", we_cnt - we0, DEPTH);
        chk("sat_m100", int'(mem[100]), 11);
        chk("sat_m601", int'(mem[601]), 51);

`ifdef MEM_COPY_CSUM_EN
        mem[700] = 200; mem[701] = 100; mem[702] = 1;
        run(700, 800, 3, 1, dc);
        chk("csum_val", int'(csum), 45);
        repeat (3) @(posedge clock);
        #1;
        chk("csum_hold", int'(csum), 45);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter M, default 8: memory word width in bits; SHALL match the attached memory's M.
REQ-002 Parameter K, default 10: address width in bits; SHALL match the attached memory's K (2^K words).
REQ-003 clock  input  1  sole clock; all state updates on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 src  input  K  first source word address; sampled with start.
REQ-007 dst  input  K  first destination word address; sampled with start.
REQ-008 len  input  K+1  word count; sampled with start.
REQ-009 busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 mem_a  output  K  memory address, driven to the memory A port.
REQ-012 mem_wd  output  M  write data, driven to the memory WD port.
REQ-013 mem_we  output  1  write enable, driven to the memory WE port.
REQ-014 mem_ra  input  M  read data from the memory RA port; combinational with mem_a.

Function
REQ-015 The FSM SHALL have four states: IDLE, READ, WRITE and DONE.
REQ-016 IDLE: start=1 captures src, dst and len; the next state is DONE if the effective length is 0, otherwise READ.
REQ-017 The effective length SHALL be min(len, 2^K); values above 2^K saturate to 2^K.
REQ-018 READ: mem_a = current source address, mem_we=0; mem_ra is latched into the data register at the clock edge; the next state is WRITE.
REQ-019 WRITE: mem_a = current destination address, mem_wd = data register, mem_we=1; the remaining count decrements by 1; the next state is READ if the remaining count is nonzero after the decrement, otherwise DONE.
REQ-020 Each word SHALL take exactly 2 cycles; a len=N copy SHALL assert done exactly 2N+1 cycles after the start edge.
REQ-021 DONE: done=1 for one cycle, busy=0; the next state is IDLE.
REQ-022 Direction: descending if d=(dst-src) mod 2^K satisfies 0<d<len; otherwise ascending. This SHALL make overlapping copies correct, matching a memmove result.
REQ-023 Ascending copies SHALL start at src/dst and step +1; descending copies SHALL start at src+len-1 and dst+len-1 and step -1.
REQ-024 All address arithmetic SHALL be modulo 2^K; wrap-around is legal.
REQ-025 src==dst with len>0 SHALL perform the full read/write sequence, leaving memory contents unchanged.
REQ-026 start asserted in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-027 Outside WRITE, mem_we SHALL be 0; outside READ and WRITE, mem_a and mem_wd SHALL be 0.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, with busy=0, done=0, mem_we=0, mem_a=0, mem_wd=0, the data register at 0 and all counters at 0.
REQ-029 Reset during a copy SHALL abort it with no further writes; words already written remain in memory.

Configuration
REQ-030 With MEM_COPY_CSUM_EN defined, the block SHALL add the output csum [M-1:0]: the modulo-2^M sum of every word written by the last copy, cleared on accepted start, valid when done=1 and held until the next accepted start.
REQ-031 Without MEM_COPY_CSUM_EN, the csum port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-032 The state encodings and the direction-select function SHALL live in the shared package mem_copy_pkg.
REQ-033 Source/destination address stepping and the count SHALL be implemented in the sub-module mem_copy_addr_gen, which has load, step and direction inputs.
REQ-034 The engine SHALL connect port-for-port to the existing single-port memory (A, WD, WE, RA), with the clock shared.

Verification
REQ-035 Preload mem[0..3]=11,22,33,44; start with src=0, dst=100, len=4 -> mem[100..103]=11,22,33,44; done 9 cycles after start; exactly 4 mem_we pulses.
REQ-036 mem[10..14]=1..5; src=10, dst=12, len=5 -> descending copy; mem[12..16]=1..5.
REQ-037 mem[1022]=7, mem[1023]=8, mem[0]=9; src=1022, dst=500, len=3 -> mem[500..502]=7,8,9 (source wraps).
REQ-038 len=0 -> done 1 cycle after start; mem_we never asserted; busy never asserted.
REQ-039 reset_n pulled low after the 2nd WRITE of a len=8 copy -> only 2 destination words changed; outputs 0 immediately; the next start works normally.
REQ-040 With MEM_COPY_CSUM_EN: copying 200,100,1 -> csum=45 (301 mod 256) at done; start pulses during busy are ignored.
